clk_en_gen: RTL
===============

CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 Parameter N_CH, default 2, number of independent divided clock-enable channels (1..8).
REQ-002 Parameter DIV_W, default 8, width of each channel divide value.
REQ-003 Parameter LOCK_CYCLES, default 16, settle cycles before Locked asserts (>=1).
REQ-004 Clk  input  1  single system clock; all logic on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Div  input  N_CH*DIV_W  per-channel divide values; channel i occupies bits [i*DIV_W +: DIV_W].
REQ-007 Div_Load  input  1  one-cycle strobe; captures Div into shadow registers.
REQ-008 Enable  input  1  run/freeze control for all channels.
REQ-009 Clk_En  output  N_CH  per-channel one-cycle enable pulse at Clk/D.
REQ-010 Clk_Sq  output  N_CH  per-channel toggle output, period 2*D cycles (50% duty).
REQ-011 Locked  output  1  high when outputs are valid and stable.

Function
REQ-012 Lock FSM states: HOLD, SETTLE, LOCKED; encoding is free, one-hot or binary.
REQ-013 HOLD is entered asynchronously on Reset; first rising edge with Reset low moves to SETTLE and clears the settle counter.
REQ-014 SETTLE counts Clk cycles; on the edge where the count reaches LOCK_CYCLES the FSM enters LOCKED and Locked is registered high.
REQ-015 Locked rises exactly LOCK_CYCLES+1 rising edges after the first edge with Reset low.
REQ-016 Div_Load high on any edge outside HOLD captures Div into shadow registers, forces SETTLE, clears the settle counter, and drops Locked on that same edge.
REQ-017 Div_Load during SETTLE restarts the settle count from zero; the latest Div is used.
REQ-018 Shadow divide D_i: values 0 and 1 both act as D=1; otherwise D_i = Div value (range 1..2^DIV_W-1).
REQ-019 Channel counters are held at 0, Clk_En held 0, and Clk_Sq held 0 whenever Locked is low.
REQ-020 With Locked and Enable high, channel counter i counts 0..D_i-1 and wraps to 0; Clk_En[i] is high for exactly the cycle the counter equals D_i-1.
REQ-021 First Clk_En[i] pulse occurs D_i cycles after Locked rises; with D_i=1, Clk_En[i] is high every cycle while running.
REQ-022 Clk_Sq[i] toggles on every cycle in which Clk_En[i] is high.
REQ-023 Enable low freezes all channel counters and Clk_Sq and forces Clk_En to 0; Locked is unaffected; counting resumes from the frozen value when Enable returns high.
REQ-024 Channels are independent; no channel's divide value affects another channel's phase except through the common Div_Load relock.
REQ-025 Simultaneous Div_Load and Enable low: Div_Load takes priority (relock occurs).
REQ-026 Clk_En, Clk_Sq, and Locked are driven directly from registers, with no combinational path from any input.

Reset
REQ-027 Reset asynchronously forces the FSM to HOLD, clears the settle counter and all channel counters, and sets Locked=0, Clk_En=0, and Clk_Sq=0.
REQ-028 Reset loads every shadow divide register with 1.
REQ-029 Reset asserted mid-count or while LOCKED takes effect immediately without waiting for a clock edge, and full lock sequencing restarts on release.

Verification
REQ-030 Defaults, Div={8'd4,8'd1}, with Div_Load pulsed on the first edge after reset release -> Locked rises 17 edges later; Clk_En[0] pulses every cycle; Clk_En[1] pulses every 4th cycle, first pulse 4 cycles after Locked; Clk_Sq[1] has period 8.
REQ-031 Locked with D=5 on channel 0; Div_Load with new Div=3 -> Locked=0 on the load edge; counters and outputs are 0 for 16 cycles; Locked returns; Clk_En[0] period is 3.
REQ-032 Div_Load pulsed twice, 5 cycles apart, during SETTLE -> Locked rises 17 edges after the second pulse, not the first.
REQ-033 Running with D=4; Enable low for 10 cycles on the cycle after counter value 1 -> no Clk_En during the freeze, Clk_Sq stable; the next pulse occurs 2 cycles after Enable returns high.
REQ-034 Reset asserted asynchronously between edges while LOCKED -> Locked, Clk_En, and Clk_Sq go to 0 before the next edge; after release, relock takes 17 edges with all shadow D=1.
REQ-035 Div=0 on a channel -> behaves identically to Div=1 (pulse every cycle, Clk_Sq at Clk/2).

Source files
------------

// File: rtl/clk_en_gen.sv
// clk_en_gen: divided clock-enable generator with a lock sequencer.
// A HOLD -> SETTLE -> LOCKED sequencer gates N_CH independent divider
// channels. Each channel emits a one-cycle Clk_En pulse every D cycles
// and a 50% duty Clk_Sq square wave with a period of 2*D cycles.
// Every output comes straight from a flop.
module clk_en_gen #(
    parameter int N_CH        = 2,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [N_CH*DIV_W-1:0]  Div,
    input  logic                   Div_Load,
    input  logic                   Enable,
    output logic [N_CH-1:0]        Clk_En,
    output logic [N_CH-1:0]        Clk_Sq,
    output logic                   Locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    lock_state_t                    r_state;
    logic [CNT_W-1:0]               r_settle_cnt;
    logic                           r_locked;
    logic [N_CH-1:0][DIV_W-1:0]     r_div;
    logic [N_CH-1:0][DIV_W-1:0]     r_ch_cnt;
    logic [N_CH-1:0]                r_en;
    logic [N_CH-1:0]                r_sq;

    logic [N_CH-1:0][DIV_W-1:0]     w_div_eff;
    logic [N_CH-1:0]                w_last;
    logic                           w_run;

    // Lock sequencer: settle for LOCK_CYCLES after reset release or any relock.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= HOLD;
            r_settle_cnt <= '0;
            r_locked     <= 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    r_state      <= SETTLE;
                    r_settle_cnt <= '0;
                    r_locked     <= 1'b0;
                end
                SETTLE: begin
                    if (Div_Load) begin
                        r_settle_cnt <= '0;
                    end else if (r_settle_cnt == CNT_W'(LOCK_CYCLES)) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (Div_Load) begin
                        r_state      <= SETTLE;
                        r_settle_cnt <= '0;
                        r_locked     <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= HOLD;
                    r_settle_cnt <= '0;
                    r_locked     <= 1'b0;
                end
            endcase
        end
    end

    // Shadow divide registers; a load strobe captures Div in any state.
    // NOTE: the shadow array is reset (to D=1) because its value decides
    // channel behaviour straight after reset release; it is not a RAM.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_div[i] <= DIV_W'(1);
            end
        end else if (Div_Load) begin
            for (int i = 0; i < N_CH; i++) begin
                r_div[i] <= Div[i*DIV_W +: DIV_W];
            end
        end
    end

    // Effective divide (0 acts as 1) and per-channel terminal-count decode.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_div_eff = '0;
        w_last    = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_div_eff[i] = (r_div[i] <= DIV_W'(1)) ? DIV_W'(1) : r_div[i];
            w_last[i]    = (r_ch_cnt[i] == w_div_eff[i] - DIV_W'(1));
        end
    end

    // Channels run only while locked; a load strobe wins over everything.
    assign w_run = r_locked && !Div_Load;

    // Channel counters and registered pulse / square outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ch_cnt <= '0;
            r_en     <= '0;
            r_sq     <= '0;
        end else if (!w_run) begin
            r_ch_cnt <= '0;
            r_en     <= '0;
            r_sq     <= '0;
        end else if (Enable) begin
            for (int i = 0; i < N_CH; i++) begin
                r_ch_cnt[i] <= w_last[i] ? '0 : r_ch_cnt[i] + DIV_W'(1);
                r_en[i]     <= w_last[i];
                r_sq[i]     <= r_sq[i] ^ w_last[i];
            end
        end else begin
            r_en <= '0;
        end
    end

    assign Clk_En = r_en;
    assign Clk_Sq = r_sq;
    assign Locked = r_locked;

endmodule
